// File: rtl/uart_ctrl_p_if.sv
// CPU bus control strobes and serial pins of uart_ctrl_p.
// The bidirectional DATA bus stays a plain port on the block.
interface uart_ctrl_p_if;
  logic [1:0] ADDR;
  logic       NCS;
  logic       NO;
  logic       NW;
  logic       NINT;
  logic       RX;
  logic       TX;

  // CPU / line side: drives strobes and the receive pin.
  modport master (output ADDR, NCS, NO, NW, RX, input NINT, TX);
  // Peripheral side.
  modport slave  (input ADDR, NCS, NO, NW, RX, output NINT, TX);
endinterface

// File: rtl/uart_ctrl_p.sv
// Full-duplex UART peripheral: 8-bit CPU bus, TX/RX FIFOs, sticky error
// flags, internal loopback and a maskable registered interrupt.
module uart_ctrl_p #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter logic [7:0]  RESET_BAUD = 8'h0F
) (
  input  logic         CLK,
  input  logic         NRST,
  inout  wire  [7:0]   DATA,
  uart_ctrl_p_if.slave bus
);

  localparam int unsigned TXA = $clog2(TX_DEPTH);
  localparam int unsigned RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_ONE   = 1;
  localparam logic [RXA:0] RX_ONE   = 1;
  localparam logic [2:0]   LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus strobes and once-per-access edge detection.
  logic rd, wr, rd_q, wr_q, rd_evt, wr_evt;
  assign rd     = ~bus.NCS & ~bus.NO;
  assign wr     = ~bus.NCS & ~bus.NW;
  assign wr_evt = wr & ~wr_q;
  assign rd_evt = rd & ~rd_q & ~wr;   // a concurrent write suppresses the pop

  // Registers and flags.
  logic       en, loop, en_d, loop_d;
  logic [3:0] intmask;
  logic [7:0] baud;
  logic       ferr, rxovr;
  logic [7:0] status, rdata;

  // TX FIFO.
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TXA:0]      tx_wp, tx_rp;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  // RX FIFO.
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RXA:0]      rx_wp, rx_rp;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;

  // TX FSM.
  state_t            tx_state, tx_state_d;
  logic [8:0]        tx_cnt, tx_cnt_d;
  logic [2:0]        tx_bit, tx_bit_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic              tx_line, tx_line_d, tx_pin, tx_busy, tx_bit_end;

  // RX FSM.
  state_t            rx_state, rx_state_d;
  logic [8:0]        rx_cnt, rx_cnt_d;
  logic [2:0]        rx_bit, rx_bit_d;
  logic [DATA_W-1:0] rx_shift, rx_shift_d;
  logic              rx_s1, rx_s2, rx_in, rx_bit_end, rx_half_end;
  logic              set_ferr, set_ovr;

  logic nint;

  // Register the strobes so each access acts on its first edge only.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!NRST) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
    end
  end

  // Next value of EN/LOOP, also used to register the TX pin without delay.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    en_d   = en;
    loop_d = loop;
    if (wr_evt && bus.ADDR == 2'd0) begin
      en_d   = DATA[0];
      loop_d = DATA[1];
    end
  end

  // Control, interrupt mask and baud registers.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      en      <= 1'b0;
      loop    <= 1'b0;
      intmask <= 4'h0;
      baud    <= RESET_BAUD;
    end else begin
      en   <= en_d;
      loop <= loop_d;
      if (wr_evt && bus.ADDR == 2'd1) intmask <= DATA[7:4];
      if (wr_evt && bus.ADDR == 2'd3 && !en) baud <= DATA;
    end
  end

  // Sticky error flags: hardware set wins over a same-edge clear.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      ferr  <= 1'b0;
      rxovr <= 1'b0;
    end else begin
      if (wr_evt && bus.ADDR == 2'd0 && DATA[7]) ferr  <= 1'b0;
      if (wr_evt && bus.ADDR == 2'd0 && DATA[5]) rxovr <= 1'b0;
      if (set_ferr) ferr  <= 1'b1;
      if (set_ovr)  rxovr <= 1'b1;
    end
  end

  // FIFO status; the extra pointer bit separates full from empty.
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TXA] != tx_rp[TXA]) && (tx_wp[TXA-1:0] == tx_rp[TXA-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RXA] != rx_rp[RXA]) && (rx_wp[RXA-1:0] == rx_rp[RXA-1:0]);
  assign tx_head  = tx_mem[tx_rp[TXA-1:0]];
  assign rx_head  = rx_mem[rx_rp[RXA-1:0]];
  assign tx_push  = wr_evt && bus.ADDR == 2'd2 && en && !tx_full;
  assign rx_pop   = rd_evt && bus.ADDR == 2'd2 && !rx_empty;

  // FIFO storage.
  always_ff @(posedge CLK) begin
    // NOTE: storage arrays are not reset; the pointers alone define validity.
    if (tx_push) tx_mem[tx_wp[TXA-1:0]] <= DATA[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp[RXA-1:0]] <= rx_shift;
  end

  // FIFO pointers.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_ONE;
      if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
      if (rx_push) rx_wp <= rx_wp + RX_ONE;
      if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
    end
  end

  // One bit period is 2*(BAUD+1) clocks, half period BAUD+1.
  assign tx_bit_end  = (tx_cnt == {baud, 1'b1});
  assign rx_bit_end  = (rx_cnt == {baud, 1'b1});
  assign rx_half_end = (rx_cnt == {1'b0, baud});
  assign tx_busy     = (tx_state != S_IDLE);

  // TX next state: frames follow back to back while the FIFO has data.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 9'd1;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_line_d  = tx_line;
    tx_pop     = 1'b0;
    if (!en) begin
      tx_state_d = S_IDLE;
      tx_cnt_d   = '0;
      tx_line_d  = 1'b1;
    end else begin
      unique case (tx_state)
        S_IDLE: begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_line_d  = 1'b0;
            tx_state_d = S_START;
          end
        end
        S_START: if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift[0];
          tx_state_d = S_DATA;
        end
        S_DATA: if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit == LAST_BIT) begin
            tx_line_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit + 3'd1;
            tx_shift_d = tx_shift >> 1;
            tx_line_d  = tx_shift[1];
          end
        end
        S_STOP: if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_line_d  = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
        default: tx_state_d = S_IDLE;
      endcase
    end
  end

  // TX state register; the pin is forced high while looping back.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_pin   <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
      tx_pin   <= loop_d ? 1'b1 : tx_line_d;
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= bus.RX;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_in = loop ? tx_line : rx_s2;

  // RX next state: mid-bit sampling, false-start rejection, stop check.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 9'd1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_push    = 1'b0;
    set_ferr   = 1'b0;
    set_ovr    = 1'b0;
    if (!en) begin
      rx_state_d = S_IDLE;
      rx_cnt_d   = '0;
    end else begin
      unique case (rx_state)
        S_IDLE: begin
          rx_cnt_d = '0;
          if (!rx_in) rx_state_d = S_START;
        end
        S_START: if (rx_half_end) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_in ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift[DATA_W-1:1]};
          if (rx_bit == LAST_BIT) rx_state_d = S_STOP;
          else                    rx_bit_d   = rx_bit + 3'd1;
        end
        S_STOP: if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (!rx_in)      set_ferr = 1'b1;
          else if (rx_full) set_ovr = 1'b1;
          else             rx_push  = 1'b1;
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  // RX state register.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  assign status = {ferr, tx_empty & ~tx_busy, rxovr, ~rx_empty,
                   tx_busy, tx_full, loop, en};

  // Read multiplexer.
  always_comb begin
    rdata = 8'h00;
    unique case (bus.ADDR)
      2'd0: rdata = status;
      2'd1: rdata = {intmask, 4'h0};
      2'd2: rdata = rx_empty ? 8'h00 : 8'(rx_head);
      2'd3: rdata = baud;
      default: rdata = 8'h00;
    endcase
  end

  assign DATA = rd ? rdata : 8'bz;

  // Registered active-low interrupt from the masked upper status bits.
  always_ff @(posedge CLK) begin
    if (!NRST) nint <= 1'b1;
    else       nint <= ~|(status[7:4] & intmask);
  end

  assign bus.NINT = nint;
  assign bus.TX   = tx_pin;

endmodule

// File: tb/tb_uart_ctrl_p.sv
// Directed self-checking bench for uart_ctrl_p (BAUD=1, i.e. 4 clocks/bit).
module tb_uart_ctrl_p;

  logic       clk = 1'b0;
  logic       nrst;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mon_st [64];
  logic       mon_ni [64];
  int         mon_n;

  uart_ctrl_p_if bif ();

  assign data = drv_en ? drv_val : 8'bz;

  uart_ctrl_p dut (
    .CLK  (clk),
    .NRST (nrst),
    .DATA (data),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] val;   // write data, or expected read value
    string      name;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bif.ADDR = a; drv_val = d; drv_en = 1'b1; bif.NCS = 1'b0; bif.NW = 1'b0;
    @(negedge clk);
    bif.NCS = 1'b1; bif.NW = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bif.ADDR = a; bif.NCS = 1'b0; bif.NO = 1'b0;
    #1 d = data;
    @(negedge clk);
    bif.NCS = 1'b1; bif.NO = 1'b1;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string name);
    logic [7:0] d;
    bus_read(a, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one frame on RX (4 clocks per bit) plus one idle bit time,
  // recording the bus data lines and NINT every cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits  = {stop, b, 1'b0};
    mon_n = 0;
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bif.RX = (i < 10) ? bits[i] : 1'b1;
        if (mon_n < 64) begin
          mon_st[mon_n] = data;
          mon_ni[mon_n] = bif.NINT;
          mon_n++;
        end
      end
    end
  endtask

  initial begin
    logic [43:0] tx_cap, tx_exp, busy_cap, busy_exp;
    logic [7:0]  pat, d;
    logic        tx_hi;
    int          fi;

    nrst = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
    bif.ADDR = 2'd0; bif.NCS = 1'b1; bif.NO = 1'b1; bif.NW = 1'b1; bif.RX = 1'b1;
    wait_clks(3);
    nrst = 1'b1;
    @(negedge clk);
    check("reset_tx", 64'(bif.TX), 64'd1);
    check("reset_nint", 64'(bif.NINT), 64'd1);

    // Register access table.
    vecs[0]  = '{1'b0, 2'd0, 8'h40, "rst_status"};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, "rst_intmask"};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, "rst_data"};
    vecs[3]  = '{1'b0, 2'd3, 8'h0F, "rst_baud"};
    vecs[4]  = '{1'b1, 2'd1, 8'hFF, "wr_intmask"};
    vecs[5]  = '{1'b0, 2'd1, 8'hF0, "intmask_upper_only"};
    vecs[6]  = '{1'b1, 2'd3, 8'h01, "wr_baud"};
    vecs[7]  = '{1'b0, 2'd3, 8'h01, "baud_written"};
    vecs[8]  = '{1'b1, 2'd0, 8'h03, "wr_ctrl_en_loop"};
    vecs[9]  = '{1'b0, 2'd0, 8'h43, "status_en_loop"};
    vecs[10] = '{1'b1, 2'd3, 8'h07, "wr_baud_while_en"};
    vecs[11] = '{1'b0, 2'd3, 8'h01, "baud_locked"};
    vecs[12] = '{1'b1, 2'd0, 8'h00, "wr_ctrl_off"};
    vecs[13] = '{1'b1, 2'd1, 8'h00, "wr_intmask_off"};
    vecs[14] = '{1'b0, 2'd0, 8'h40, "status_off"};
    vecs[15] = '{1'b0, 2'd1, 8'h00, "intmask_off"};
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].val);
      else            read_check(vecs[i].addr, vecs[i].val, vecs[i].name);
    end

    // Transmit 8'hA5 and watch TX and TXBUSY every clock.
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'hA5);
    bif.ADDR = 2'd0; bif.NCS = 1'b0; bif.NO = 1'b0;
    pat = 8'hA5;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      tx_cap[k]   = bif.TX;
      busy_cap[k] = data[3];
      if (k < 4)       tx_exp[k] = 1'b0;
      else if (k < 36) tx_exp[k] = pat[(k / 4) - 1];
      else             tx_exp[k] = 1'b1;
      busy_exp[k] = (k < 40);
    end
    bif.NCS = 1'b1; bif.NO = 1'b1;
    check("tx_waveform_a5", 64'(tx_cap), 64'(tx_exp));
    check("txbusy_40_clocks", 64'(busy_cap), 64'(busy_exp));

    // Internal loopback of two characters; the pin must stay high.
    bus_write(2'd0, 8'h03);
    bus_write(2'd2, 8'h3C);
    bus_write(2'd2, 8'hC3);
    tx_hi = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      tx_hi &= bif.TX;
    end
    check("loop_tx_pin_high", 64'(tx_hi), 64'd1);
    read_check(2'd0, 8'h53, "loop_status_rxne");
    read_check(2'd2, 8'h3C, "loop_rx_first");
    read_check(2'd2, 8'hC3, "loop_rx_second");
    read_check(2'd0, 8'h43, "loop_status_drained");

    // A DATA write strobe held for 5 cycles pushes exactly one entry.
    @(negedge clk);
    bif.ADDR = 2'd2; drv_val = 8'h5A; drv_en = 1'b1; bif.NCS = 1'b0; bif.NW = 1'b0;
    wait_clks(5);
    bif.NCS = 1'b1; bif.NW = 1'b1; drv_en = 1'b0;
    wait_clks(100);
    read_check(2'd2, 8'h5A, "held_write_byte");
    read_check(2'd0, 8'h43, "held_write_single");

    // Clearing EN mid-frame aborts the transmitter.
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'h77);
    wait_clks(10);
    read_check(2'd0, 8'h09, "midframe_busy");
    bus_write(2'd0, 8'h00);
    wait_clks(2);
    read_check(2'd0, 8'h40, "en_clear_idle");
    check("en_clear_tx_high", 64'(bif.TX), 64'd1);

    // Overrun: RX_DEPTH+1 frames without reading.
    bus_write(2'd0, 8'h01);
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
    read_check(2'd0, 8'h71, "ovr_status");
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd2, d);
      check($sformatf("ovr_rx_%0d", i), 64'(d), 64'(8'h10 + i));
    end
    read_check(2'd0, 8'h61, "ovr_drained");
    bus_write(2'd0, 8'h20);
    read_check(2'd0, 8'h40, "ovr_cleared");

    // Framing error with FERR unmasked; NINT follows one cycle later.
    bus_write(2'd0, 8'h01);
    bus_write(2'd1, 8'h80);
    @(negedge clk);
    check("nint_masked_idle", 64'(bif.NINT), 64'd1);
    bif.ADDR = 2'd0; bif.NCS = 1'b0; bif.NO = 1'b0;
    send_frame(8'h96, 1'b0);
    bif.NCS = 1'b1; bif.NO = 1'b1;
    fi = -1;
    for (int i = 0; i < mon_n - 1; i++)
      if (fi < 0 && mon_st[i][7] === 1'b1) fi = i;
    check("ferr_seen", 64'(fi >= 0), 64'd1);
    if (fi >= 0) begin
      check("nint_at_ferr_edge", 64'(mon_ni[fi]), 64'd1);
      check("nint_one_cycle_later", 64'(mon_ni[fi + 1]), 64'd0);
    end
    wait_clks(10);
    read_check(2'd0, 8'hC1, "ferr_status_no_rxne");
    bus_write(2'd0, 8'h81);
    @(negedge clk);
    check("nint_released", 64'(bif.NINT), 64'd1);
    read_check(2'd0, 8'h41, "ferr_cleared");
    bus_write(2'd1, 8'h00);

    // Low pulse shorter than half a bit is rejected.
    @(negedge clk);
    bif.RX = 1'b0;
    @(negedge clk);
    bif.RX = 1'b1;
    wait_clks(20);
    read_check(2'd0, 8'h41, "glitch_rejected");
    read_check(2'd2, 8'h00, "glitch_no_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ctrl_p.md
Name: uart_ctrl_p

Overview:
- Parametrised successor of the single-channel serial peripheral: full-duplex UART with an 8-bit CPU bus, a TX FIFO, an RX FIFO and a receiver.
- Adds sticky error flags, internal loopback and a maskable interrupt.
- Sits between the CPU bus (ADDR/NCS/NO/NW/DATA/NINT) and the serial pins RX/TX.
- Frame format: 1 start bit, DATA_W data bits LSB first, 1 stop bit, no parity.

Parameters:
- DATA_W, 8, character width (5..8); unused upper DATA bits read 0 and are ignored on write.
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=2).
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=2).
- RESET_BAUD, 8'h0F, BAUD register value after reset.

Ports:
- CLK  in  1  clock.
- NRST  in  1  reset, synchronous, active-low.
- ADDR  in  2  register select: 0 CTRL/STATUS, 1 INTMASK, 2 DATA, 3 BAUD.
- NCS  in  1  negative chip select.
- NO  in  1  negative read enable.
- NW  in  1  negative write enable.
- DATA  inout  8  CPU data; driven only while NCS=0 & NO=0, otherwise high-Z (combinational).
- NINT  out  1  negative interrupt, registered.
- RX  in  1  serial receive, asynchronous.
- TX  out  1  serial transmit, registered, idle high.

Behaviour:
- Reset (NRST=0 at a CLK edge):
  - CTRL=0, INTMASK=0, BAUD=RESET_BAUD.
  - Both FIFOs empty; all sticky flags cleared.
  - TX=1, NINT=1; TX and RX FSMs return to IDLE.
  - Reset wins over any simultaneous access.
- Access strobes:
  - rd = ~NCS & ~NO; wr = ~NCS & ~NW.
  - Side effects (push, pop, register write) occur once per access, on the first CLK edge where the strobe is high after being low on the previous edge.
  - A held strobe produces no further effects. rd and wr both high: write wins, no pop.
- CTRL write (ADDR 0):
  - bit0 EN, bit1 LOOP.
  - Writing 1 to bit5 clears RXOVR; writing 1 to bit7 clears FERR.
- STATUS read (ADDR 0):
  - [0] EN, [1] LOOP, [2] TXFULL, [3] TXBUSY, [4] RXNE, [5] RXOVR, [6] TXEMPTY (FIFO empty & !TXBUSY), [7] FERR.
- INTMASK (ADDR 1): read/write; only bits [7:4] are implemented, bits [3:0] read 0.
  - NINT(next) = ~|(STATUS[7:4] & INTMASK[7:4]), i.e. one cycle after the flag changes.
- DATA (ADDR 2):
  - Write pushes the TX FIFO; dropped silently if full or EN=0.
  - Read returns the RX FIFO head (0 if empty). The pop occurs at the access edge, and the next read sees the following entry.
- BAUD (ADDR 3): writable only when EN=0, otherwise the write is ignored.
  - Bit period P = 2*(BAUD+1) clocks; half period H = BAUD+1.
- TX FSM: IDLE -> START -> DATA(DATA_W bits) -> STOP -> IDLE.
  - Leaves IDLE on the edge where EN=1 & TX FIFO non-empty, popping the entry; TX goes 0 on that edge.
  - Each state lasts exactly P clocks.
  - Back-to-back frames have no idle gap. TXBUSY=1 outside IDLE.
- RX path:
  - RX passes through a 2-flop synchroniser; with LOOP=1 the receiver input is the internal TX signal and the TX pin is held at 1.
  - IDLE: when EN=1 and the synchronised input is 0, wait H clocks. If the input is then 1 (false start), return to IDLE; otherwise sample DATA_W bits every P clocks, then the stop bit P later.
  - Stop bit = 0: set FERR, discard the byte.
  - RX FIFO full: set RXOVR, discard the byte (existing contents kept).
  - Otherwise push the byte. A pop and a push on the same edge are both honoured.
- EN cleared mid-frame: both FSMs return to IDLE on the next edge, TX=1, the partial RX byte is discarded, and FIFO contents are kept.
- FIFO pointers wrap modulo depth; full/empty are derived from an extra pointer bit.

Test Plan:
- Reset, then read all four registers -> STATUS=8'h40 (TXEMPTY), INTMASK=0, DATA=0, BAUD=8'h0F; TX=1, NINT=1.
- BAUD=1 (P=4), EN=1, write 8'hA5 -> TX: 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 (4 clocks each), then 1 for 4; TXBUSY high for 40 clocks.
- LOOP=1, EN=1, write 8'h3C, 8'hC3 -> RXNE=1 after the second frame; two reads return 8'h3C, 8'hC3; TX pin stays 1 throughout.
- Inject RX_DEPTH+1 frames with no reads -> RXOVR=1 after the last frame; reads return the first RX_DEPTH bytes in order; writing 8'h20 to CTRL clears RXOVR.
- RX frame with stop bit 0 -> FERR=1, RXNE unchanged; with INTMASK=8'h80, NINT=0 one cycle after FERR sets.
- RX low pulse of H-1 clocks -> no byte and no flag; a DATA write held for 5 cycles pushes exactly one entry.
